// File: rtl/pio_arb_pkg.sv
// pio_arb_pkg: shared opcodes, grant ids and FSM encoding for pio_arbiter
package pio_arb_pkg;
    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_MWRITE = 2'b10;
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_ACK} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker
module rr_arb2
    import pio_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_id_o
);
    assign grant_valid_o = |req_i;
    assign grant_id_o    = &req_i ? (last_grant_i == REQ_A ? REQ_B : REQ_A)
                                  : (req_i[REQ_B] ? REQ_B : REQ_A);
endmodule

// File: rtl/pio_arbiter.sv
// pio_arbiter: shares one pio_port between two requesters with read, write and read-modify-write
module pio_arbiter
    import pio_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic [1:0]        op_a,
    input  logic              rs_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] mask_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic [1:0]        op_b,
    input  logic              rs_b,
    input  logic [DATA_W-1:0] wdata_b,
    input  logic [DATA_W-1:0] mask_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              pio_en,
    output logic              pio_rden,
    output logic              pio_wren,
    output logic              pio_rs,
    output logic [DATA_W-1:0] pio_wdata,
    input  logic [DATA_W-1:0] pio_rdata,
    output logic              busy
);
    state_t            state_q, state_d;
    logic [1:0]        op_q, win_op;
    logic              rs_q, id_q, last_q, gnt_valid, gnt_id;
    logic [DATA_W-1:0] wdata_q, mask_q, hold_q, rdata_a_q, rdata_b_q;

    rr_arb2 u_rr_arb2 (
        .req_i        ({req_b, req_a}),
        .last_grant_i (last_q),
        .grant_valid_o(gnt_valid),
        .grant_id_o   (gnt_id)
    );

    assign win_op = gnt_id == REQ_B ? op_b : op_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= REQ_B;
            op_q      <= OP_READ;
            rs_q      <= 1'b0;
            id_q      <= REQ_A;
            wdata_q   <= '0;
            mask_q    <= '0;
            hold_q    <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && gnt_valid) begin
                op_q    <= win_op;
                rs_q    <= gnt_id == REQ_B ? rs_b : rs_a;
                wdata_q <= gnt_id == REQ_B ? wdata_b : wdata_a;
                mask_q  <= gnt_id == REQ_B ? mask_b : mask_a;
                id_q    <= gnt_id;
                last_q  <= gnt_id;
            end
            if (state_q == S_CAP) hold_q <= pio_rdata;
            if (ack_a) rdata_a_q <= rdata_a;
            if (ack_b) rdata_b_q <= rdata_b;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = !gnt_valid ? S_IDLE : win_op == OP_WRITE ? S_WR : S_RD;
            S_RD:    state_d = S_CAP;
            S_CAP:   state_d = op_q == OP_MWRITE ? S_WR : S_ACK;
            S_WR:    state_d = S_ACK;
            default: state_d = S_IDLE;
        endcase
    end

    // rdata is presented combinationally during the ack cycle, then held in the _q copy
    always_comb begin
        pio_en    = state_q inside {S_RD, S_CAP, S_WR};
        pio_rden  = state_q inside {S_RD, S_CAP};
        pio_wren  = state_q == S_WR;
        pio_rs    = pio_en & rs_q;
        pio_wdata = !pio_wren ? '0
                  : op_q == OP_MWRITE ? (hold_q & ~mask_q) | (wdata_q & mask_q) : wdata_q;
        ack_a     = state_q == S_ACK && id_q == REQ_A;
        ack_b     = state_q == S_ACK && id_q == REQ_B;
        rdata_a   = ack_a && op_q != OP_WRITE ? hold_q : rdata_a_q;
        rdata_b   = ack_b && op_q != OP_WRITE ? hold_q : rdata_b_q;
        busy      = state_q != S_IDLE;
    end
endmodule

// File: tb/tb_pio_arbiter.sv
// tb_pio_arbiter: scoreboard-driven self-checking bench for pio_arbiter with a small pio_port model
module tb_pio_arbiter;
    logic       clk = 1'b0, rst = 1'b1;
    logic       req_a = 0, rs_a = 0, ack_a, req_b = 0, rs_b = 0, ack_b;
    logic [1:0] op_a = 0, op_b = 0;
    logic [7:0] wdata_a = 0, mask_a = 0, rdata_a, wdata_b = 0, mask_b = 0, rdata_b;
    logic       pio_en, pio_rden, pio_wren, pio_rs, busy;
    logic [7:0] pio_wdata, pio_rdata;
    logic [7:0] pins = 8'h5A, out_lat = 8'h00, ctrl = 8'h00;
    int         chk = 0, pass = 0;

    typedef struct {bit who; int lat; logic [7:0] rd;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pio_arbiter #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .op_a(op_a), .rs_a(rs_a), .wdata_a(wdata_a), .mask_a(mask_a),
        .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .op_b(op_b), .rs_b(rs_b), .wdata_b(wdata_b), .mask_b(mask_b),
        .ack_b(ack_b), .rdata_b(rdata_b),
        .pio_en(pio_en), .pio_rden(pio_rden), .pio_wren(pio_wren), .pio_rs(pio_rs),
        .pio_wdata(pio_wdata), .pio_rdata(pio_rdata), .busy(busy)
    );

    // pio_port model: rs=0 reads pins, rs=1 reads io_control; writes land on posedge
    assign pio_rdata = (pio_en & pio_rden) ? (pio_rs ? ctrl : pins) : 8'h00;
    always @(posedge clk) if (pio_en & pio_wren) begin
        if (pio_rs) ctrl <= pio_wdata;
        else out_lat <= pio_wdata;
    end

    task automatic run_cmd(input bit who, input logic [1:0] op, input logic rs,
                           input logic [7:0] wd, input logic [7:0] mk,
                           output int lat, output int nrd, output int nwr,
                           output logic [7:0] wval, output logic wrs, output bit other,
                           output logic [7:0] rd);
        lat = -1; nrd = 0; nwr = 0; wval = 8'h00; wrs = 1'b0; other = 0; rd = 8'hxx;
        if (!who) begin op_a = op; rs_a = rs; wdata_a = wd; mask_a = mk; req_a = 1; end
        else begin op_b = op; rs_b = rs; wdata_b = wd; mask_b = mk; req_b = 1; end
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (pio_en & pio_rden) nrd++;
            if (pio_en & pio_wren) begin nwr++; wval = pio_wdata; wrs = pio_rs; end
            if (who ? ack_a : ack_b) other = 1;
            if (who ? ack_b : ack_a) begin lat = n; rd = who ? rdata_b : rdata_a; break; end
        end
        req_a = 0; req_b = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk++; if ({busy, ack_a, ack_b, pio_en, pio_rden, pio_wren, pio_rs} !== 7'b0)
            $display("FAIL reset_ctrl: got %b exp 0000000", {busy, ack_a, ack_b, pio_en, pio_rden, pio_wren, pio_rs}); else pass++;
        chk++; if ({pio_wdata, rdata_a, rdata_b} !== 24'h0)
            $display("FAIL reset_data: got %h exp 000000", {pio_wdata, rdata_a, rdata_b}); else pass++;
        rst = 0;
    endtask

    task automatic test_write_a();
        int lat, nrd, nwr; logic [7:0] wv, rd; logic wr; bit oth; exp_t e;
        sb.push_back('{1'b0, 2, 8'h00});
        @(negedge clk);
        run_cmd(1'b0, 2'b01, 1'b1, 8'hF0, 8'h00, lat, nrd, nwr, wv, wr, oth, rd);
        e = sb.pop_front();
        chk++; if (lat !== e.lat) $display("FAIL wr_a_latency: got %0d exp %0d", lat, e.lat); else pass++;
        chk++; if ({nrd, nwr} !== {32'd0, 32'd1}) $display("FAIL wr_a_strobes: got rd=%0d wr=%0d exp rd=0 wr=1", nrd, nwr); else pass++;
        chk++; if ({wr, wv} !== {1'b1, 8'hF0}) $display("FAIL wr_a_bus: got rs=%b data=%h exp rs=1 data=f0", wr, wv); else pass++;
        chk++; if (ctrl !== 8'hF0) $display("FAIL wr_a_ctrl: got %h exp f0", ctrl); else pass++;
        chk++; if ({oth, rd} !== {1'b0, e.rd}) $display("FAIL wr_a_rdata: got other=%b rdata=%h exp other=0 rdata=%h", oth, rd, e.rd); else pass++;
    endtask

    task automatic test_read_b();
        int lat, nrd, nwr; logic [7:0] wv, rd; logic wr; bit oth; exp_t e;
        pins = 8'h5A;
        sb.push_back('{1'b1, 3, 8'h5A});
        @(negedge clk);
        run_cmd(1'b1, 2'b00, 1'b0, 8'h00, 8'h00, lat, nrd, nwr, wv, wr, oth, rd);
        e = sb.pop_front();
        chk++; if (lat !== e.lat) $display("FAIL rd_b_latency: got %0d exp %0d", lat, e.lat); else pass++;
        chk++; if ({nrd, nwr} !== {32'd2, 32'd0}) $display("FAIL rd_b_strobes: got rd=%0d wr=%0d exp rd=2 wr=0", nrd, nwr); else pass++;
        chk++; if ({oth, rd} !== {1'b0, e.rd}) $display("FAIL rd_b_rdata: got other=%b rdata=%h exp other=0 rdata=%h", oth, rd, e.rd); else pass++;
        pins = 8'h00;
        repeat (2) @(negedge clk);
        chk++; if ({rdata_b, rdata_a} !== {e.rd, 8'h00}) $display("FAIL rd_b_hold: got b=%h a=%h exp b=%h a=00", rdata_b, rdata_a, e.rd); else pass++;
    endtask

    task automatic test_mwrite();
        int lat, nrd, nwr; logic [7:0] wv, rd; logic wr; bit oth; exp_t e;
        pins = 8'hA5;
        sb.push_back('{1'b0, 4, 8'hA5});
        @(negedge clk);
        run_cmd(1'b0, 2'b10, 1'b0, 8'h03, 8'h0F, lat, nrd, nwr, wv, wr, oth, rd);
        e = sb.pop_front();
        chk++; if (lat !== e.lat) $display("FAIL mw_a_latency: got %0d exp %0d", lat, e.lat); else pass++;
        chk++; if ({nrd, nwr} !== {32'd2, 32'd1}) $display("FAIL mw_a_strobes: got rd=%0d wr=%0d exp rd=2 wr=1", nrd, nwr); else pass++;
        chk++; if ({wr, wv, out_lat} !== {1'b0, 8'hA3, 8'hA3}) $display("FAIL mw_a_merge: got rs=%b data=%h latch=%h exp rs=0 data=a3 latch=a3", wr, wv, out_lat); else pass++;
        chk++; if ({oth, rd} !== {1'b0, e.rd}) $display("FAIL mw_a_rdata: got other=%b rdata=%h exp other=0 rdata=%h", oth, rd, e.rd); else pass++;
        // mask of zero rewrites the value just read back
        sb.push_back('{1'b1, 4, 8'hF0});
        @(negedge clk);
        run_cmd(1'b1, 2'b10, 1'b1, 8'hFF, 8'h00, lat, nrd, nwr, wv, wr, oth, rd);
        e = sb.pop_front();
        chk++; if ({lat, wv, ctrl} !== {e.lat, 8'hF0, 8'hF0}) $display("FAIL mw_zero_mask: got lat=%0d data=%h ctrl=%h exp lat=%0d data=f0 ctrl=f0", lat, wv, ctrl, e.lat); else pass++;
        chk++; if (rd !== e.rd) $display("FAIL mw_zero_rdata: got %h exp %h", rd, e.rd); else pass++;
        // opcode 11 behaves as a read
        sb.push_back('{1'b1, 3, 8'hF0});
        @(negedge clk);
        run_cmd(1'b1, 2'b11, 1'b1, 8'h00, 8'hFF, lat, nrd, nwr, wv, wr, oth, rd);
        e = sb.pop_front();
        chk++; if ({lat, nwr, rd} !== {e.lat, 32'd0, e.rd}) $display("FAIL op11_read: got lat=%0d wr=%0d rdata=%h exp lat=%0d wr=0 rdata=%h", lat, nwr, rd, e.lat, e.rd); else pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e; int acks = 0, last_ack = 0, both = 0;
        pins = 8'h3C;
        for (int i = 0; i < 4; i++) sb.push_back('{bit'(i % 2), 4, (i % 2) ? 8'h3C : 8'hF0});
        @(negedge clk);
        op_a = 2'b00; rs_a = 1; op_b = 2'b00; rs_b = 0; req_a = 1; req_b = 1;
        for (int n = 1; n <= 40 && acks < 4; n++) begin
            @(negedge clk);
            if (ack_a & ack_b) both++;
            if (ack_a | ack_b) begin
                e = sb.pop_front();
                chk++; if ({ack_b, ack_b ? rdata_b : rdata_a} !== {e.who, e.rd})
                    $display("FAIL rr_order%0d: got b=%b rdata=%h exp b=%b rdata=%h", acks, ack_b, ack_b ? rdata_b : rdata_a, e.who, e.rd); else pass++;
                if (acks > 0) begin
                    chk++; if (n - last_ack !== e.lat) $display("FAIL rr_gap%0d: got %0d exp %0d", acks, n - last_ack, e.lat); else pass++;
                end
                last_ack = n; acks++;
                if (acks == 4) begin req_a = 0; req_b = 0; end
            end
        end
        req_a = 0; req_b = 0;
        chk++; if ({acks, both} !== {32'd4, 32'd0}) $display("FAIL rr_count: got acks=%0d both=%0d exp acks=4 both=0", acks, both); else pass++;
        sb.delete();
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        repeat (2) @(negedge clk);
        op_a = 2'b00; rs_a = 0; req_a = 1;
        repeat (2) @(negedge clk);
        chk++; if ({busy, pio_en, pio_rden} !== 3'b111) $display("FAIL mid_in_cap: got %b exp 111", {busy, pio_en, pio_rden}); else pass++;
        rst = 1; req_a = 0;
        @(negedge clk);
        chk++; if ({busy, ack_a, pio_en, rdata_a} !== 11'h0) $display("FAIL mid_reset: got busy=%b ack=%b en=%b rdata=%h exp all 0", busy, ack_a, pio_en, rdata_a); else pass++;
        rst = 0;
        repeat (6) begin @(negedge clk); if (ack_a | ack_b | busy) stray++; end
        chk++; if (stray !== 0) $display("FAIL mid_no_ack: got %0d stray cycles exp 0", stray); else pass++;
    endtask

    initial begin
        test_reset();
        test_write_a();
        test_read_b();
        test_mwrite();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
